// File: rtl/dataflow_pkg.sv
// Shared definitions for the dataflow operator network: FSM encoding and
// the layout of a FIFO word (token data with the end-of-stream flag on top).
package dataflow_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The last flag always occupies the MSB of a FIFO word.
    function automatic int last_flag_pos(input int word_width);
        return word_width - 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational first-word read and registered
// full/empty/level status.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic [AW:0]      level_next;
    logic             full_reg;
    logic             empty_reg;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
    assign pop_ok  = pop && !empty_reg;
    assign push_ok = push && (!full_reg || pop_ok);

    always_comb begin
        level_next = level_reg;
        if (push_ok && !pop_ok) begin
            level_next = level_reg + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            level_next = level_reg - (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;
            full_reg  <= (level_next == DEPTH_L);
            empty_reg <= (level_next == '0);
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;
    assign level = level_reg;

endmodule

// File: rtl/data_source.sv
// Graph-input stream transmitter: host-loaded tokens are replayed on the
// R/D token interface, one per enabled cycle, after a START pulse.
module data_source
    import dataflow_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          WR_EN,
    input  logic [N-1:0]  WR_DATA,
    input  logic          WR_LAST,
    output logic          FULL,
    output logic          EMPTY,
    output logic [AW:0]   LEVEL,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic          OVF,
    output logic          R_OUT,
    output logic [N-1:0]  D_OUT
);

    localparam int LAST_BIT = last_flag_pos(N + 1);

    state_t       state_reg;
    logic         r_out_reg;
    logic [N-1:0] d_out_reg;
    logic         busy_reg;
    logic         done_reg;
    logic         ovf_reg;

    logic [N:0]   fifo_dout;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;

    assign pop = (state_reg == ST_RUN) && EN && !fifo_empty;

    sync_fifo #(
        .WIDTH (N + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (WR_EN),
        .pop   (pop),
        .din   ({WR_LAST, WR_DATA}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (LEVEL)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            r_out_reg <= 1'b0;
            d_out_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (EN) begin
                case (state_reg)
                    ST_IDLE: begin
                        r_out_reg <= 1'b0;
                        if (START) begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                            ovf_reg   <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (!fifo_empty) begin
                            r_out_reg <= 1'b1;
                            d_out_reg <= fifo_dout[N-1:0];
                            if (fifo_dout[LAST_BIT]) begin
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            r_out_reg <= 1'b0;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
            // A dropped push records overflow even on the edge that accepts START.
            if (WR_EN && fifo_full && !pop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign FULL  = fifo_full;
    assign EMPTY = fifo_empty;
    assign BUSY  = busy_reg;
    assign DONE  = done_reg;
    assign OVF   = ovf_reg;
    assign R_OUT = r_out_reg;
    assign D_OUT = d_out_reg;

endmodule

// File: tb/tb_data_source.sv
// Self-checking bench for data_source: directed scenarios plus random
// traffic compared cycle by cycle against a queue-based token model.
module tb_data_source;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        WR_EN;
    logic [15:0] WR_DATA;
    logic        WR_LAST;
    logic        FULL;
    logic        EMPTY;
    logic [4:0]  LEVEL;
    logic        START;
    logic        BUSY;
    logic        DONE;
    logic        OVF;
    logic        R_OUT;
    logic [15:0] D_OUT;

    data_source #(.N(16), .DEPTH(16), .AW(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .WR_EN   (WR_EN),
        .WR_DATA (WR_DATA),
        .WR_LAST (WR_LAST),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .LEVEL   (LEVEL),
        .START   (START),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .OVF     (OVF),
        .R_OUT   (R_OUT),
        .D_OUT   (D_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        en;
        logic        wr;
        logic [15:0] data;
        logic        last;
        logic        st;
    } stim_t;

    localparam logic [26:0] RESET_VEC = {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};

    int checks = 0;
    int errors = 0;

    // Reference model: the queued tokens and the externally visible state.
    logic [16:0] m_q[$];
    logic        m_run;
    logic        m_r;
    logic [15:0] m_d;
    logic        m_done;
    logic        m_ovf;

    logic [15:0] obs_q[$];
    logic [15:0] exp_tok[$];
    int          done_cnt;
    stim_t       sq[$];

    function automatic void model_reset();
        m_q.delete();
        m_run  = 1'b0;
        m_r    = 1'b0;
        m_d    = 16'h0000;
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    function automatic logic [26:0] exp_vec();
        int sz = m_q.size();
        return {m_r, m_d, m_run, m_done, m_ovf, (sz == 16), (sz == 0), 5'(sz)};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {R_OUT, D_OUT, BUSY, DONE, OVF, FULL, EMPTY, LEVEL};
    endfunction

    function automatic void add(input logic en, input logic wr, input logic [15:0] data,
                                input logic last, input logic st);
        stim_t s;
        s.en = en; s.wr = wr; s.data = data; s.last = last; s.st = st;
        sq.push_back(s);
    endfunction

    // Drive one cycle, advance the model across the edge, record emitted tokens.
    task automatic cycle(input stim_t s);
        logic        pop;
        logic [16:0] tok;
        EN = s.en; WR_EN = s.wr; WR_DATA = s.data; WR_LAST = s.last; START = s.st;
        @(posedge CLK);
        pop    = m_run && s.en && (m_q.size() > 0);
        m_done = 1'b0;
        if (s.en) begin
            if (!m_run) begin
                m_r = 1'b0;
                if (s.st) begin
                    m_run = 1'b1;
                    m_ovf = 1'b0;
                end
            end else if (pop) begin
                tok = m_q.pop_front();
                m_r = 1'b1;
                m_d = tok[15:0];
                if (tok[16]) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end else begin
                m_r = 1'b0;
            end
        end
        if (s.wr) begin
            if (m_q.size() < 16) m_q.push_back({s.last, s.data});
            else                 m_ovf = 1'b1;
        end
        #1;
        if (s.en && R_OUT) begin
            obs_q.push_back(D_OUT);
            $display("token emitted: data=%h at %0t", D_OUT, $time);
        end
        if (DONE) done_cnt++;
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b0; WR_EN = 1'b0; WR_DATA = '0; WR_LAST = 1'b0; START = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), RESET_VEC);
        end
        RST = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        sq.delete(); obs_q.delete(); done_cnt = 0;
        add(1, 1, 16'h0001, 0, 0);
        add(1, 1, 16'h0002, 0, 0);
        add(1, 1, 16'h0003, 1, 0);
        add(1, 0, 16'h0000, 0, 1);
        repeat (6) add(1, 0, 16'h0000, 0, 0);
        foreach (sq[i]) begin
            cycle(sq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        exp_tok = '{16'h0001, 16'h0002, 16'h0003};
        checks++;
        if (obs_q != exp_tok || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_stream: got %0d tokens %0d dones, expected 3 tokens 1 done",
                     obs_q.size(), done_cnt);
        end
    endtask

    task automatic test_en_toggle();
        logic en_pat[5] = '{1, 0, 0, 1, 1};
        sq.delete(); obs_q.delete(); done_cnt = 0;
        add(1, 1, 16'h0001, 0, 0);
        add(1, 1, 16'h0002, 0, 0);
        add(1, 1, 16'h0003, 1, 0);
        add(1, 0, 16'h0000, 0, 1);
        for (int i = 0; i < 5; i++) add(en_pat[i], 0, 16'h0000, 0, 0);
        repeat (3) add(1, 0, 16'h0000, 0, 0);
        foreach (sq[i]) begin
            cycle(sq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL en_toggle cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        exp_tok = '{16'h0001, 16'h0002, 16'h0003};
        checks++;
        if (obs_q != exp_tok || done_cnt != 1) begin
            errors++;
            $display("FAIL en_toggle_stream: got %0d tokens %0d dones, expected 3 tokens 1 done",
                     obs_q.size(), done_cnt);
        end
    endtask

    task automatic test_underrun();
        sq.delete(); obs_q.delete(); done_cnt = 0;
        add(1, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0000, 0, 0);
        add(1, 0, 16'h0000, 0, 0);
        add(1, 1, 16'hAAAA, 1, 0);
        repeat (4) add(1, 0, 16'h0000, 0, 0);
        foreach (sq[i]) begin
            cycle(sq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL underrun cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        exp_tok = '{16'hAAAA};
        checks++;
        if (obs_q != exp_tok || done_cnt != 1) begin
            errors++;
            $display("FAIL underrun_stream: got %0d tokens %0d dones, expected 1 token 1 done",
                     obs_q.size(), done_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        sq.delete(); obs_q.delete(); done_cnt = 0; exp_tok.delete();
        for (int i = 0; i < 17; i++) begin
            d = 16'($urandom);
            add(1, 1, d, (i == 15), 0);
            if (i < 16) exp_tok.push_back(d);
        end
        foreach (sq[i]) begin
            cycle(sq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_fill cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (FULL !== 1'b1 || OVF !== 1'b1 || LEVEL !== 5'd16) begin
            errors++;
            $display("FAIL overflow_flags: got full=%b ovf=%b level=%0d expected 1 1 16",
                     FULL, OVF, LEVEL);
        end
        cycle(stim_t'{1'b1, 1'b0, 16'h0, 1'b0, 1'b1});
        checks++;
        if (OVF !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL overflow_start_clears: got ovf=%b busy=%b expected 0 1", OVF, BUSY);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(stim_t'{1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_drain cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (obs_q != exp_tok || done_cnt != 1) begin
            errors++;
            $display("FAIL overflow_stream: got %0d tokens %0d dones, expected 16 tokens 1 done",
                     obs_q.size(), done_cnt);
        end
    endtask

    task automatic test_full_wrap();
        logic [15:0] d;
        sq.delete(); obs_q.delete(); done_cnt = 0; exp_tok.delete();
        for (int i = 0; i < 16; i++) begin
            d = 16'($urandom);
            add(1, 1, d, 0, 0);
            exp_tok.push_back(d);
        end
        add(1, 0, 16'h0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            d = 16'($urandom);
            add(1, 1, d, 0, 0);
            exp_tok.push_back(d);
        end
        repeat (3) add(1, 0, 16'h0, 0, 0);
        d = 16'($urandom);
        add(1, 1, d, 1, 0);
        exp_tok.push_back(d);
        repeat (20) add(1, 0, 16'h0, 0, 0);
        foreach (sq[i]) begin
            cycle(sq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_wrap cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (i >= 17 && i < 37) begin
                checks++;
                if (LEVEL !== 5'd16 || OVF !== 1'b0) begin
                    errors++;
                    $display("FAIL full_wrap_level cyc%0d: got level=%0d ovf=%b expected 16 0",
                             i, LEVEL, OVF);
                end
            end
        end
        checks++;
        if (obs_q != exp_tok || done_cnt != 1) begin
            errors++;
            $display("FAIL full_wrap_stream: got %0d tokens %0d dones, expected %0d tokens 1 done",
                     obs_q.size(), done_cnt, exp_tok.size());
        end
    endtask

    task automatic test_reset_mid();
        sq.delete(); obs_q.delete(); done_cnt = 0;
        for (int i = 0; i < 5; i++) add(1, 1, 16'(16'h0100 + i), (i == 4), 0);
        add(1, 0, 16'h0, 0, 1);
        repeat (2) add(1, 0, 16'h0, 0, 0);
        foreach (sq[i]) begin
            cycle(sq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_pre cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected %h", dut_vec(), RESET_VEC);
        end
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sq.delete(); obs_q.delete();
        add(1, 0, 16'h0, 0, 1);
        repeat (6) add(1, 0, 16'h0, 0, 0);
        foreach (sq[i]) begin
            cycle(sq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_post cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_no_tokens: got %0d tokens expected 0", obs_q.size());
        end
        // Leave the design idle for the next scenario.
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_random();
        stim_t s;
        obs_q.delete(); done_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            s.en   = ($urandom_range(0, 3) != 0);
            s.wr   = ($urandom_range(0, 1) == 1);
            s.data = 16'($urandom);
            s.last = ($urandom_range(0, 7) == 0);
            s.st   = ($urandom_range(0, 9) == 0);
            cycle(s);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_en_toggle();
        test_underrun();
        test_overflow();
        test_full_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_source.md
Name: data_source

Overview:
- Stream transmitter for the dataflow operator network.
- A host loads tokens into an internal FIFO, each tagged with an end-of-stream flag.
- After START, the block emits one token per enabled cycle on the R/D token interface consumed by operator inputs (R_IN/D_IN).
- It sits at the graph input, opposite the result sinks.

Parameters:
- N, 16, token data width
- DEPTH, 16, FIFO depth in tokens; must be a power of two, minimum 2
- AW, 4, log2(DEPTH)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous active-high reset
- EN  in  1  global dataflow enable; when 0, the token output and FSM freeze
- WR_EN  in  1  host push strobe
- WR_DATA  in  N  host token data
- WR_LAST  in  1  marks the pushed token as the final token of the stream
- FULL  out  1  FIFO holds DEPTH tokens
- EMPTY  out  1  FIFO holds 0 tokens
- LEVEL  out  AW+1  current token count, 0..DEPTH
- START  in  1  one-cycle pulse that begins emission
- BUSY  out  1  high while in RUN
- DONE  out  1  one-cycle pulse after the last token is emitted
- OVF  out  1  sticky: a push was attempted while FULL
- R_OUT  out  1  token valid to downstream operator
- D_OUT  out  N  token data

Behaviour:
- Reset (async, any time, including mid-stream):
  - R_OUT=0, D_OUT=0, BUSY=0, DONE=0, OVF=0.
  - FIFO pointers and LEVEL are cleared; stored tokens are discarded.
  - FSM goes to IDLE.
- FIFO (N+1 bits wide: data plus last flag):
  - Push occurs when WR_EN=1 and FULL=0. Push is independent of EN and FSM state.
  - Push with FULL=1 drops the token and sets OVF. OVF is cleared only by reset or by an accepted START.
  - FULL, EMPTY and LEVEL are registered and reflect the state after each edge.
  - Simultaneous push and pop: both take effect and LEVEL is unchanged; legal when FULL=1.
  - A token pushed at edge k is poppable at edge k+1 at the earliest.
  - Pointers wrap modulo DEPTH; LEVEL saturates naturally at DEPTH.
- FSM states: IDLE, RUN.
- IDLE:
  - R_OUT<=0 on every enabled edge.
  - START=1 with EN=1 gives RUN, BUSY=1, OVF cleared.
  - START with EN=0 is ignored and not remembered.
- RUN, EN=1, EMPTY=0:
  - Pop one token; D_OUT<=data, R_OUT<=1.
  - If the popped last flag is 1, go to IDLE, BUSY<=0, DONE<=1 for exactly one cycle.
- RUN, EN=1, EMPTY=1 (underrun):
  - R_OUT<=0, D_OUT holds, stay in RUN waiting for data.
- RUN, EN=0:
  - No pop; R_OUT and D_OUT hold their values; state holds.
- START while in RUN is ignored.
- Latency: START accepted at edge t means the first R_OUT=1 appears after edge t+1, assuming EN=1 and the FIFO is non-empty. Afterwards, one token per enabled cycle.
- DONE is asserted in the cycle after the last token's R_OUT=1 edge. R_OUT drops to 0 on the following enabled edge.
- If the FIFO contains tokens after a last-flagged token, they remain queued for the next START.

Decomposition:
- Shared package dataflow_pkg:
  - FSM state encodings: IDLE=0, RUN=1.
  - Token-flag bit position constant (last flag = MSB of FIFO word).
- Sub-module sync_fifo: parameters WIDTH, DEPTH, AW. Ports: push/pop, din/dout, full/empty/level; first-word available combinationally on dout.
- data_source instantiates sync_fifo with WIDTH=N+1 and holds the FSM, output registers and OVF.

Test Plan:
- Push 0x0001, 0x0002, 0x0003(last); START with EN=1 -> R_OUT=1 for three consecutive cycles with D_OUT 1,2,3; DONE pulses once; BUSY falls; LEVEL=0.
- Same stream, EN toggled 1,0,0,1,1 during emission -> R_OUT/D_OUT hold during EN=0 cycles; tokens 1,2,3 each emitted exactly once, in order.
- START with an empty FIFO, then push 0xAAAA(last) three cycles later -> R_OUT=0 until one edge after the push, then a single 0xAAAA token followed by DONE.
- Push DEPTH+1 tokens -> FULL=1 after 16 pushes, OVF=1, LEVEL=16; the 17th token is never emitted; the next START clears OVF.
- FIFO full and in RUN, push each cycle -> LEVEL stays 16, no OVF, emitted data in push order across pointer wrap.
- Assert RST mid-stream after 2 of 5 tokens -> all outputs immediately 0 (async); LEVEL=0; a subsequent START with no pushes produces no tokens.
